data_bus_master_arbiter: RTL



---
 rtl/data_bus_master_arbiter_pkg.sv | 19 +
 rtl/data_bus_master_arbiter_rr_priority_picker.sv | 33 +++
 rtl/data_bus_master_arbiter.sv | 116 +++++++++++
 3 files changed

// File: rtl/data_bus_master_arbiter_pkg.sv
// Shared definitions for the data-bus master arbiter.
//   data_bus_master_t    : symbolic master indices on the SoC data bus
//   NUM_DATA_BUS_MASTERS : number of masters sharing the data bus
//   arb_state_e          : arbiter transaction state
package data_bus_master_arbiter_pkg;

  typedef enum logic [0:0] {
    DATA_BUS_MASTER_CORE = 1'b0,
    DATA_BUS_MASTER_DBG  = 1'b1
  } data_bus_master_t;

  localparam int NUM_DATA_BUS_MASTERS = 2;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_OUTST = 1'b1
  } arb_state_e;

endpackage

// File: rtl/data_bus_master_arbiter_rr_priority_picker.sv
// Round-robin priority picker (purely combinational).
//   i_req   : request vector, one bit per requester
//   i_last  : index granted last; scanning starts just after it
//   o_valid : at least one request is set
//   o_idx   : winning index, always < N
module rr_priority_picker #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic          o_valid,
  output logic [IW-1:0] o_idx
);

  logic [IW-1:0] w_cand;

  // Scan from the farthest candidate towards the nearest so that the last
  // hit (the one closest after i_last) is the one that sticks.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    w_cand  = '0;
    for (int i = N; i >= 1; i--) begin
      w_cand = IW'((int'(i_last) + i) % N);
      if (i_req[w_cand]) begin
        o_valid = 1'b1;
        o_idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/data_bus_master_arbiter.sv
// Data-bus master arbiter: shares one downstream bus between NUM_MASTERS
// masters with round-robin arbitration and a single outstanding transaction.
//   clk, rst             : clock, asynchronous active-high reset
//   m_req/we/be/addr/wdata : per-master request bundles (flattened, master 0 in LSBs)
//   m_gnt, m_rvalid, m_rdata : per-master grant / response valid, shared read data
//   s_req/we/be/addr/wdata : downstream request
//   s_gnt, s_rvalid, s_rdata : downstream grant and response
//   owner, busy, err     : owner of outstanding transaction, outstanding flag,
//                          sticky spurious-response flag
module data_bus_master_arbiter
  import data_bus_master_arbiter_pkg::*;
#(
  parameter  int NUM_MASTERS = NUM_DATA_BUS_MASTERS,
  localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_MASTERS-1:0]    m_req,
  input  logic [NUM_MASTERS-1:0]    m_we,
  input  logic [NUM_MASTERS*4-1:0]  m_be,
  input  logic [NUM_MASTERS*32-1:0] m_addr,
  input  logic [NUM_MASTERS*32-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]    m_gnt,
  output logic [NUM_MASTERS-1:0]    m_rvalid,
  output logic [31:0]               m_rdata,
  output logic                      s_req,
  output logic                      s_we,
  output logic [3:0]                s_be,
  output logic [31:0]               s_addr,
  output logic [31:0]               s_wdata,
  input  logic                      s_gnt,
  input  logic                      s_rvalid,
  input  logic [31:0]               s_rdata,
  output logic [MW-1:0]             owner,
  output logic                      busy,
  output logic                      err
);

  arb_state_e    r_state, w_state_nxt;
  logic [MW-1:0] r_owner;
  logic [MW-1:0] r_last_grant;
  logic          r_err;

  logic          w_valid;
  logic [MW-1:0] w_winner;
  logic          w_issue;
  logic          w_hs;

  rr_priority_picker #(.N(NUM_MASTERS)) u_picker (
    .i_req   (m_req),
    .i_last  (r_last_grant),
    .o_valid (w_valid),
    .o_idx   (w_winner)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ARB_IDLE;
      r_owner      <= '0;
      r_last_grant <= MW'(NUM_MASTERS - 1);
      r_err        <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_hs) begin
        r_owner      <= w_winner;
        r_last_grant <= w_winner;
      end
      if (r_state == ARB_IDLE && s_rvalid) begin
        r_err <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    s_req       = 1'b0;
    s_we        = 1'b0;
    s_be        = '0;
    s_addr      = '0;
    s_wdata     = '0;
    m_gnt       = '0;
    m_rvalid    = '0;
    m_rdata     = s_rdata;

    // A response in the same cycle frees the single slot, so a new request
    // may go out alongside it for back-to-back throughput.
    w_issue = (r_state == ARB_IDLE) || s_rvalid;

    if (w_issue && w_valid) begin
      s_req           = 1'b1;
      s_we            = m_we[w_winner];
      s_be            = m_be[int'(w_winner)*4 +: 4];
      s_addr          = m_addr[int'(w_winner)*32 +: 32];
      s_wdata         = m_wdata[int'(w_winner)*32 +: 32];
      m_gnt[w_winner] = s_gnt;
    end
    w_hs = s_req & s_gnt;

    // Response goes to the registered owner, even if a new handshake is
    // replacing it in this same cycle.
    if (r_state == ARB_OUTST) begin
      m_rvalid[r_owner] = s_rvalid;
    end

    if (w_hs) begin
      w_state_nxt = ARB_OUTST;
    end else if (r_state == ARB_OUTST && s_rvalid) begin
      w_state_nxt = ARB_IDLE;
    end
  end

  assign owner = r_owner;
  assign busy  = (r_state == ARB_OUTST);
  assign err   = r_err;

endmodule
